param_acc_cpu: RTL

PARAM_ACC_CPU -- requirements
Module: param_acc_cpu

---
 rtl/acc_cpu_pkg.sv | 32 +++
 rtl/acc_cpu_alu.sv | 58 +++++
 rtl/param_acc_cpu.sv | 127 ++++++++++++
 3 files changed

// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the parameterised accumulator CPU: opcode values,
// FSM state encoding, flag bit positions and an opcode classification helper.
package acc_cpu_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_STORE = 4'd2;
    localparam logic [3:0] OP_LOAD  = 4'd3;
    localparam logic [3:0] OP_LDI   = 4'd4;
    localparam logic [3:0] OP_AND   = 4'd5;
    localparam logic [3:0] OP_OR    = 4'd6;
    localparam logic [3:0] OP_XOR   = 4'd7;
    localparam logic [3:0] OP_NOT   = 4'd8;
    localparam logic [3:0] OP_SHL   = 4'd9;
    localparam logic [3:0] OP_SHR   = 4'd10;
    localparam logic [3:0] OP_ADDM  = 4'd11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_e;

    // flags = {carry, zero}
    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;

    // True for every opcode that replaces the accumulator (and so the flags).
    function automatic logic op_writes_acc(input logic [3:0] op);
        return (op <= OP_ADDM) && (op != OP_STORE);
    endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// Purely combinational datapath of the accumulator CPU. Non-accumulator
// opcodes (STORE, NOP) pass the accumulator through with carry cleared.
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] acc_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [DATA_W-1:0] mem_i,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o
);

    logic [DATA_W:0] ext;

    // Select the operation; ext carries the extra bit for carry/borrow.
    always_comb begin
        ext      = '0;
        result_o = acc_i;
        carry_o  = 1'b0;
        case (op_i)
            OP_ADD: begin
                ext      = {1'b0, acc_i} + {1'b0, data_i};
                result_o = ext[DATA_W-1:0];
                carry_o  = ext[DATA_W];
            end
            OP_SUB: begin
                // Top bit of the extended difference is the borrow.
                ext      = {1'b0, acc_i} - {1'b0, data_i};
                result_o = ext[DATA_W-1:0];
                carry_o  = ext[DATA_W];
            end
            OP_LOAD: result_o = mem_i;
            OP_LDI:  result_o = data_i;
            OP_AND:  result_o = acc_i & data_i;
            OP_OR:   result_o = acc_i | data_i;
            OP_XOR:  result_o = acc_i ^ data_i;
            OP_NOT:  result_o = ~acc_i;
            OP_SHL: begin
                result_o = {acc_i[DATA_W-2:0], 1'b0};
                carry_o  = acc_i[DATA_W-1];
            end
            OP_SHR: begin
                result_o = {1'b0, acc_i[DATA_W-1:1]};
                carry_o  = acc_i[0];
            end
            OP_ADDM: begin
                ext      = {1'b0, acc_i} + {1'b0, mem_i};
                result_o = ext[DATA_W-1:0];
                carry_o  = ext[DATA_W];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/param_acc_cpu.sv
// Parameterised accumulator CPU: two-state IDLE/EXEC handshake, operand
// capture on accept, result/memory/flag update on the EXEC->IDLE edge.
// Optional feature macro: ACC_CPU_FLAGS_EN (implements the {carry, zero}
// flags register; when undefined, flags is tied to zero).
module param_acc_cpu
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [3:0]        opcode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] acc_out,
    output logic              done,
    output logic [1:0]        flags
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_e            state_q;
    logic [3:0]        opcode_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] acc_q;
    logic              done_q;

    // Memory must clear on reset, so it is held in registers rather than RAM.
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_rd;

    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              exec_now;

    assign exec_now = (state_q == ST_EXEC);
    assign mem_rd   = mem_q[addr_q];

    acc_cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op_i     (opcode_q),
        .acc_i    (acc_q),
        .data_i   (data_q),
        .mem_i    (mem_rd),
        .result_o (alu_result),
        .carry_o  (alu_carry)
    );

    // Handshake FSM: capture on accept, commit accumulator and pulse done on exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            opcode_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            acc_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (op_valid) begin
                        opcode_q <= opcode;
                        addr_q   <= addr;
                        data_q   <= data;
                        state_q  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // ALU passes acc through for STORE/NOP, so always loading is safe.
                    acc_q   <= alu_result;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Word store on the commit edge of a STORE; whole array clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (exec_now && (opcode_q == OP_STORE)) begin
            mem_q[addr_q] <= acc_q;
        end
    end

`ifdef ACC_CPU_FLAGS_EN
    logic carry_q;
    logic zero_q;

    // Flags follow every accumulator-writing commit; STORE/NOP keep them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else if (exec_now && op_writes_acc(opcode_q)) begin
            carry_q <= alu_carry;
            zero_q  <= (alu_result == '0);
        end
    end

    // Place the flag bits at their packed positions.
    always_comb begin
        flags             = '0;
        flags[FLAG_CARRY] = carry_q;
        flags[FLAG_ZERO]  = zero_q;
    end
`else
    logic unused_carry;
    assign unused_carry = alu_carry;
    assign flags        = 2'b00;
`endif

    assign op_ready = (state_q == ST_IDLE);
    assign acc_out  = acc_q;
    assign done     = done_q;

endmodule
